// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-RAM port arbiter: arbiter states and
// read-return owner tags.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        CORE,
        EXT,
        FAIR
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_EXT
    } owner_t;

endpackage

// File: rtl/imem_arb_rsp_route.sv
// Steers the 1-cycle-latency RAM read data back to whichever requester was
// granted a read in the previous cycle; the other side holds its last data.
module imem_arb_rsp_route
    import imem_arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  owner_t        grant_owner,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata
);

    owner_t        owner_q;
    logic [DW-1:0] core_hold_q;
    logic [DW-1:0] ext_hold_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= OWN_NONE;
            core_hold_q <= '0;
            ext_hold_q  <= '0;
        end else begin
            owner_q     <= grant_owner;
            core_hold_q <= core_rdata;
            ext_hold_q  <= ext_rdata;
        end
    end

    always_comb begin
        core_rvalid = (owner_q == OWN_CORE);
        ext_rvalid  = (owner_q == OWN_EXT);
        core_rdata  = core_rvalid ? mem_rdata : core_hold_q;
        ext_rdata   = ext_rvalid  ? mem_rdata : ext_hold_q;
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction RAM between core fetch and the program
// loader. Optional write protection while the core runs: IMEM_ARB_WRPROTECT_EN.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int          AW         = 12,
    parameter int          DW         = 32,
    parameter int          MAX_BURST  = 8,
    parameter logic [31:0] START_ADDR = 32'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_req,
    input  logic [AW-1:0] core_addr,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    output logic          core_restart,
    output logic [31:0]   core_restart_pc,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_err,
    input  logic          core_run,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            CW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] burst_q, burst_d;
    logic          wr_seen_q;
    logic          leave_ext;
    logic          wr_block;
    owner_t        grant_owner;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        burst_d  = burst_q;
        core_gnt = 1'b0;
        ext_gnt  = 1'b0;
        // Grants are suppressed while reset is asserted so all outputs read 0.
        if (rst_n) begin
            case (state_q)
                CORE: begin
                    core_gnt = core_req;
                    if (ext_req) state_d = EXT;
                end
                EXT: begin
                    if (ext_req) begin
                        ext_gnt = 1'b1;
                        if (burst_q != BURST_LAST) burst_d = burst_q + 1'b1;
                        // The fairness slot is only offered to a running core.
                        if (burst_q == BURST_LAST && core_req && core_run) state_d = FAIR;
                    end else begin
                        state_d = CORE;
                        burst_d = '0;
                    end
                end
                FAIR: begin
                    core_gnt = core_req;
                    burst_d  = '0;
                    state_d  = ext_req ? EXT : CORE;
                end
                default: state_d = CORE;
            endcase
            if (core_gnt) burst_d = '0;
        end
    end

    // End of a loader session, whether it leaves from EXT or from the fair slot.
    assign leave_ext = (state_q != CORE) && (state_d == CORE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CORE;
            burst_q      <= '0;
            wr_seen_q    <= 1'b0;
            core_restart <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            core_restart <= leave_ext && wr_seen_q;
            if (leave_ext && wr_seen_q) wr_seen_q <= 1'b0;
            else if (ext_gnt && ext_we) wr_seen_q <= 1'b1;
        end
    end

`ifdef IMEM_ARB_WRPROTECT_EN
    assign wr_block = ext_gnt && ext_we && core_run;
`else
    assign wr_block = 1'b0;
`endif

    assign ext_err         = wr_block;
    assign core_restart_pc = START_ADDR;

    always_comb begin
        mem_en      = core_gnt || ext_gnt;
        mem_we      = ext_gnt && ext_we && !wr_block;
        mem_addr    = core_gnt ? core_addr : (ext_gnt ? ext_addr : '0);
        mem_wdata   = ext_gnt ? ext_wdata : '0;
        // Writes return nothing, so only read grants claim the return path.
        grant_owner = core_gnt ? OWN_CORE : ((ext_gnt && !ext_we) ? OWN_EXT : OWN_NONE);
    end

    imem_arb_rsp_route #(
        .DW (DW)
    ) u_rsp_route (
        .clk         (clk),
        .rst_n       (rst_n),
        .grant_owner (grant_owner),
        .mem_rdata   (mem_rdata),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .ext_rvalid  (ext_rvalid),
        .ext_rdata   (ext_rdata)
    );

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 1-cycle-latency RAM.
// Build with IMEM_ARB_WRPROTECT_EN defined to exercise write protection.
module tb_imem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

`ifdef IMEM_ARB_WRPROTECT_EN
    localparam logic          EXP_ERR = 1'b1;
    localparam logic          EXP_WE  = 1'b0;
    localparam logic [DW-1:0] EXP_RD  = 32'hA500_0004;
`else
    localparam logic          EXP_ERR = 1'b0;
    localparam logic          EXP_WE  = 1'b1;
    localparam logic [DW-1:0] EXP_RD  = 32'hDEAD_BEEF;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_req, core_gnt, core_rvalid, core_restart;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_rdata;
    logic [31:0]   core_restart_pc;
    logic          ext_req, ext_we, ext_gnt, ext_rvalid, ext_err;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic          core_run;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    always #5 clk = ~clk;

    imem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(8), .START_ADDR(32'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_addr(core_addr), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .core_restart(core_restart), .core_restart_pc(core_restart_pc),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .ext_err(ext_err),
        .core_run(core_run),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = init_val(i);
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; core_req = 0; core_addr = '0; core_run = 0;
        ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({core_gnt, core_rvalid, core_restart, ext_gnt, ext_rvalid, ext_err, mem_en, mem_we} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 00000000",
                {core_gnt, core_rvalid, core_restart, ext_gnt, ext_rvalid, ext_err, mem_en, mem_we});
        end
        n_checks++;
        if ({core_rdata, ext_rdata, mem_wdata} !== '0 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_buses: core_rdata %h ext_rdata %h mem_wdata %h mem_addr %h want 0",
                core_rdata, ext_rdata, mem_wdata, mem_addr);
        end
        n_checks++;
        if (core_restart_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc: got %h want 00000000", core_restart_pc);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_core_fetch();
        core_run = 1; core_req = 1; core_addr = 12'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (core_gnt !== 1'b1 || ext_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 ||
                mem_addr !== 12'(i)) begin
                n_fail++;
                $display("FAIL fetch_gnt[%0d]: gnt %b ext_gnt %b en %b we %b addr %h want 1 0 1 0 %h",
                    i, core_gnt, ext_gnt, mem_en, mem_we, mem_addr, 12'(i));
            end
            @(negedge clk);
            n_checks++;
            if (core_rvalid !== 1'b1 || core_rdata !== init_val(i) || ext_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_data[%0d]: rvalid %b rdata %h ext_rvalid %b want 1 %h 0",
                    i, core_rvalid, core_rdata, ext_rvalid, init_val(i));
            end
            if (i < 3) core_addr = 12'(i + 1);
            else core_req = 0;
        end
        @(negedge clk);
        n_checks++;
        if (core_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL fetch_idle_rvalid: got %b want 0", core_rvalid);
        end
    endtask

    task automatic test_load();
        int n_ext = 0;
        int n_core = 0;
        int n_we_bad = 0;
        core_run = 0; ext_req = 1; ext_we = 1; ext_addr = 12'h10; ext_wdata = 32'h1000_0000;
        #1;
        n_checks++;
        if (ext_gnt !== 1'b0 || core_gnt !== 1'b0 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL load_first_cycle: ext_gnt %b core_gnt %b mem_en %b want 0 0 0",
                ext_gnt, core_gnt, mem_en);
        end
        @(negedge clk);
        core_req = 1;
        for (int k = 0; k < 16; k++) begin
            ext_addr  = 12'h10 + 12'(k);
            ext_wdata = 32'h1000_0000 + 32'(k);
            #1;
            n_ext  += int'(ext_gnt);
            n_core += int'(core_gnt);
            if (!(mem_we && mem_addr == ext_addr && mem_wdata == ext_wdata)) n_we_bad++;
            @(negedge clk);
        end
        n_checks++;
        if (n_ext != 16 || n_core != 0) begin
            n_fail++; $display("FAIL load_grants: ext %0d core %0d want 16 0", n_ext, n_core);
        end
        n_checks++;
        if (n_we_bad != 0) begin
            n_fail++; $display("FAIL load_mem_write: bad cycles %0d want 0", n_we_bad);
        end
        ext_req = 0; core_req = 0;
        #1;
        n_checks++;
        if (core_restart !== 1'b0) begin
            n_fail++; $display("FAIL load_restart_early: got %b want 0", core_restart);
        end
        @(negedge clk);
        n_checks++;
        if (core_restart !== 1'b1 || core_restart_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL load_restart: restart %b pc %h want 1 00000000", core_restart, core_restart_pc);
        end
        @(negedge clk);
        n_checks++;
        if (core_restart !== 1'b0) begin
            n_fail++; $display("FAIL load_restart_width: got %b want 0", core_restart);
        end
        core_req = 1; core_addr = 12'h10;
        @(negedge clk);
        n_checks++;
        if (core_rdata !== 32'h1000_0000) begin
            n_fail++; $display("FAIL load_readback_10: got %h want 10000000", core_rdata);
        end
        core_addr = 12'h1F;
        @(negedge clk);
        n_checks++;
        if (core_rdata !== 32'h1000_000F) begin
            n_fail++; $display("FAIL load_readback_1f: got %h want 1000000f", core_rdata);
        end
        core_req = 0;
        @(negedge clk);
    endtask

    task automatic test_fair();
        core_run = 1; core_req = 1; core_addr = 12'h3;
        ext_req = 1; ext_we = 0; ext_addr = 12'h10;
        for (int c = 0; c < 28; c++) begin
            logic exp_core;
            exp_core = (c == 0) || (((c - 1) % 9) == 8);
            #1;
            n_checks++;
            if (core_gnt !== exp_core || ext_gnt !== !exp_core) begin
                n_fail++;
                $display("FAIL fair_pattern[%0d]: core_gnt %b ext_gnt %b want %b %b",
                    c, core_gnt, ext_gnt, exp_core, !exp_core);
            end
            @(negedge clk);
        end
        core_req = 0; ext_req = 0;
        @(negedge clk);
        n_checks++;
        if (core_restart !== 1'b0) begin
            n_fail++; $display("FAIL fair_no_restart: got %b want 0", core_restart);
        end
    endtask

    task automatic test_ext_read();
        logic [AW-1:0] addrs [3];
        logic [DW-1:0] exps  [3];
        logic          rst_seen;
        addrs[0] = 12'h10; exps[0] = 32'h1000_0000;
        addrs[1] = 12'h11; exps[1] = 32'h1000_0001;
        addrs[2] = 12'h05; exps[2] = 32'hA500_0005;
        ext_req = 1; ext_we = 0; ext_addr = addrs[0];
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            ext_addr = addrs[k];
            #1;
            n_checks++;
            if (ext_gnt !== 1'b1 || mem_we !== 1'b0) begin
                n_fail++; $display("FAIL rd_gnt[%0d]: gnt %b we %b want 1 0", k, ext_gnt, mem_we);
            end
            @(negedge clk);
            n_checks++;
            if (ext_rvalid !== 1'b1 || ext_rdata !== exps[k] || core_rvalid !== 1'b0 ||
                core_rdata !== 32'hA500_0003) begin
                n_fail++;
                $display("FAIL rd_data[%0d]: rvalid %b rdata %h core_rvalid %b core_rdata %h want 1 %h 0 a5000003",
                    k, ext_rvalid, ext_rdata, core_rvalid, core_rdata, exps[k]);
            end
        end
        ext_req = 0;
        rst_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            rst_seen |= core_restart;
        end
        n_checks++;
        if (rst_seen !== 1'b0) begin
            n_fail++; $display("FAIL rd_no_restart: got %b want 0", rst_seen);
        end
    endtask

    task automatic test_reset_mid();
        core_run = 1; core_req = 1; core_addr = 12'h2;
        #1;
        n_checks++;
        if (core_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_gnt: got %b want 1", core_gnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({core_gnt, core_rvalid, core_restart, ext_gnt, ext_rvalid, ext_err, mem_en} !== 7'b0 ||
            core_rdata !== '0 || ext_rdata !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: strobes %b core_rdata %h ext_rdata %h want 0",
                {core_gnt, core_rvalid, core_restart, ext_gnt, ext_rvalid, ext_err, mem_en},
                core_rdata, ext_rdata);
        end
        @(negedge clk);
        n_checks++;
        if (core_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_rvalid: got %b want 0", core_rvalid);
        end
        core_req = 0;
        rst_n = 1'b1;
        @(negedge clk);
        core_req = 1; ext_req = 1; ext_we = 0; ext_addr = 12'h0;
        #1;
        n_checks++;
        if (core_gnt !== 1'b1 || ext_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_state_core: core_gnt %b ext_gnt %b want 1 0", core_gnt, ext_gnt);
        end
        @(negedge clk);
        core_req = 0; ext_req = 0;
        @(negedge clk);
        n_checks++;
        if (core_restart !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_no_restart: got %b want 0", core_restart);
        end
    endtask

    task automatic test_wrprotect();
        core_req = 0; core_run = 1;
        ext_req = 1; ext_we = 1; ext_addr = 12'h4; ext_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        #1;
        n_checks++;
        if (ext_gnt !== 1'b1 || ext_err !== EXP_ERR || mem_we !== EXP_WE) begin
            n_fail++;
            $display("FAIL wp_write: gnt %b err %b mem_we %b want 1 %b %b",
                ext_gnt, ext_err, mem_we, EXP_ERR, EXP_WE);
        end
        @(negedge clk);
        ext_we = 0;
        #1;
        n_checks++;
        if (ext_gnt !== 1'b1 || ext_err !== 1'b0) begin
            n_fail++; $display("FAIL wp_read_gnt: gnt %b err %b want 1 0", ext_gnt, ext_err);
        end
        @(negedge clk);
        n_checks++;
        if (ext_rvalid !== 1'b1 || ext_rdata !== EXP_RD) begin
            n_fail++;
            $display("FAIL wp_readback: rvalid %b rdata %h want 1 %h", ext_rvalid, ext_rdata, EXP_RD);
        end
        ext_req = 0;
        @(negedge clk);
        n_checks++;
        if (core_restart !== 1'b1) begin
            n_fail++; $display("FAIL wp_restart: got %b want 1", core_restart);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_core_fetch();
        test_load();
        test_fair();
        test_ext_read();
        test_reset_mid();
        test_wrprotect();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
